sha256_msg_schedule: RTL and testbench

- Upstream producer for the SHA-256 round datapath. Accepts one 512-bit padded message block and streams the 64 schedule words W[0..63], one per handshake.
- Words 16..63 are computed as a 4-operand modulo-2^32 sum: sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16].
- That sum feeds the same 4-operand compressor arithmetic used downstream.

---
 rtl/sha256_pkg.sv | 36 +++
 rtl/sha256_small_sigma.sv | 19 +
 rtl/sha256_msg_schedule.sv | 161 ++++++++++++++++
 tb/tb_sha256_msg_schedule.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, state encoding and arithmetic helpers for the
// SHA-256 message-schedule block.
package sha256_pkg;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 512;
    localparam int ROUNDS  = 64;

    // Small-sigma rotate/shift amounts.
    localparam int S0_ROT1 = 7;
    localparam int S0_ROT2 = 18;
    localparam int S0_SHR  = 3;
    localparam int S1_ROT1 = 17;
    localparam int S1_ROT2 = 19;
    localparam int S1_SHR  = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Rotate right by a constant amount (1..31).
    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
        return (x >> n) | (x << (32'(WORD_W) - n));
    endfunction

    // Four-operand modulo-2^32 sum; all carries out of bit 31 are dropped.
    function automatic logic [WORD_W-1:0] add4(input logic [WORD_W-1:0] a,
                                               input logic [WORD_W-1:0] b,
                                               input logic [WORD_W-1:0] c,
                                               input logic [WORD_W-1:0] d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// sha256_small_sigma: combinational SHA-256 small sigma function.
// SEL = 0 gives sigma0 (ROTR7 ^ ROTR18 ^ SHR3),
// SEL = 1 gives sigma1 (ROTR17 ^ ROTR19 ^ SHR10).
module sha256_small_sigma
    import sha256_pkg::*;
#(
    parameter int SEL = 0
) (
    input  logic [31:0] x,
    output logic [31:0] y
);

    localparam int ROT1 = (SEL == 0) ? S0_ROT1 : S1_ROT1;
    localparam int ROT2 = (SEL == 0) ? S0_ROT2 : S1_ROT2;
    localparam int SHR  = (SEL == 0) ? S0_SHR  : S1_SHR;

    assign y = rotr(x, ROT1) ^ rotr(x, ROT2) ^ (x >> SHR);

endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: accepts one 512-bit padded block and streams the
// ROUNDS schedule words W[0..ROUNDS-1] over a valid/ready interface.
// A 16-word sliding window holds W[t..t+15]; each accepted word shifts the
// window and appends the next expanded word, so words 16+ have no extra latency.
// Optional macro SHA256_SCHED_BACK2BACK_EN: accept the next block during the
// final word so blocks stream with no idle cycle between them.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = sha256_pkg::ROUNDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLOCK_W-1:0] blk_data,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [WORD_W-1:0]  w_data,
    output logic [5:0]         w_idx,
    output logic               w_last
);

`ifdef SHA256_SCHED_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_e            state_r, state_s;
    logic [5:0]        t_r, t_s;
    logic [WORD_W-1:0] win_r [16];
    logic [WORD_W-1:0] win_s [16];
    logic              valid_r, valid_s;
    logic              last_r, last_s;
    logic              ready_r, ready_s;
    logic [WORD_W-1:0] s0_s, s1_s, next_w_s;
    logic              blk_hs_s, w_hs_s;

    sha256_small_sigma #(.SEL(0)) u_sigma0 (.x(win_r[1]),  .y(s0_s));
    sha256_small_sigma #(.SEL(1)) u_sigma1 (.x(win_r[14]), .y(s1_s));

    assign next_w_s = add4(s1_s, win_r[9], s0_s, win_r[0]);

`ifdef SHA256_SCHED_BACK2BACK_EN
    // In RUN the block may only be taken together with the final word, so a
    // stalled final word must not let the new block be accepted and lost.
    assign blk_ready = ready_r & (~valid_r | w_ready);
`else
    assign blk_ready = ready_r;
`endif

    assign blk_hs_s = blk_valid & blk_ready;
    assign w_hs_s   = valid_r & w_ready;

    assign w_valid = valid_r;
    assign w_data  = win_r[0];
    assign w_idx   = t_r;
    assign w_last  = last_r;

    // Next-state, window update and registered-output decode.
    always_comb begin
        state_s = state_r;
        t_s     = t_r;
        valid_s = valid_r;
        last_s  = last_r;
        ready_s = ready_r;
        for (int i = 0; i < 16; i++) begin
            win_s[i] = win_r[i];
        end

        if (abort) begin
            state_s = IDLE;
            t_s     = 6'd0;
            valid_s = 1'b0;
            last_s  = 1'b0;
            ready_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (blk_hs_s) begin
                        for (int i = 0; i < 16; i++) begin
                            win_s[i] = blk_data[BLOCK_W-1-32*i -: 32];
                        end
                        state_s = RUN;
                        t_s     = 6'd0;
                        valid_s = 1'b1;
                        last_s  = 1'b0;
                        ready_s = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    if (w_hs_s && (t_r == LAST_IDX)) begin
                        if (B2B && blk_hs_s) begin
                            for (int i = 0; i < 16; i++) begin
                                win_s[i] = blk_data[BLOCK_W-1-32*i -: 32];
                            end
                            state_s = RUN;
                            t_s     = 6'd0;
                            valid_s = 1'b1;
                            last_s  = 1'b0;
                            ready_s = 1'b0;
                        end else begin
                            state_s = IDLE;
                            t_s     = 6'd0;
                            valid_s = 1'b0;
                            last_s  = 1'b0;
                            ready_s = 1'b1;
                        end
                    end else if (w_hs_s) begin
                        for (int i = 0; i < 15; i++) begin
                            win_s[i] = win_r[i+1];
                        end
                        win_s[15] = next_w_s;
                        t_s       = t_r + 6'd1;
                        last_s    = ((t_r + 6'd1) == LAST_IDX);
                        ready_s   = B2B && ((t_r + 6'd1) == LAST_IDX);
                    end else begin
                        state_s = RUN;
                    end
                end
                default: begin
                    state_s = IDLE;
                    t_s     = 6'd0;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                    ready_s = 1'b1;
                end
            endcase
        end
    end

    // State, index, window and output registers with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            t_r     <= 6'd0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            ready_r <= 1'b1;
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= 32'h0000_0000;
            end
        end else begin
            state_r <= state_s;
            t_r     <= t_s;
            valid_r <= valid_s;
            last_r  <= last_s;
            ready_r <= ready_s;
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= win_s[i];
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: randomized self-checking bench for the SHA-256
// message schedule against a direct W[t] recurrence model.
module tb_sha256_msg_schedule;

    localparam int ROUNDS = 64;
`ifdef SHA256_SCHED_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         abort;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         w_last;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] msg   [16];
    logic [31:0] exp_w [64];
    logic [31:0] got   [64];

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_last    (w_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [511:0] pack_msg();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = msg[i];
        return b;
    endfunction

    task automatic compute_expected();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) exp_w[t] = msg[t];
            else exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0000_0000;
        msg[0]  = 32'h6162_6380;
        msg[15] = 32'h0000_0018;
    endtask

    // Offer msg, stream all words (optionally random w_ready, optional abort at index abort_at).
    task automatic stream(input bit rnd, input int abort_at, input string name);
        int k;
        int budget;
        logic exp_last;
        compute_expected();
        @(negedge clk);
        w_ready = 1'b0;
        chk_cnt++;
        if (blk_ready !== 1'b1) $display("FAIL %s_idle_ready got=%b want=1", name, blk_ready);
        else pass_cnt++;
        blk_data  = pack_msg();
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        k = 0;
        budget = 0;
        while (k < ROUNDS && budget < 1000) begin
            if (abort_at >= 0 && k == abort_at) begin
                abort   = 1'b1;
                w_ready = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk_cnt++;
                if ({w_valid, w_idx, w_last, blk_ready} !== {1'b0, 6'd0, 1'b0, 1'b1})
                    $display("FAIL %s_abort got v=%b idx=%0d last=%b rdy=%b want v=0 idx=0 last=0 rdy=1",
                             name, w_valid, w_idx, w_last, blk_ready);
                else pass_cnt++;
                return;
            end
            w_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            exp_last = (k == ROUNDS - 1);
            chk_cnt++;
            if ({w_valid, w_data, w_idx, w_last} !== {1'b1, exp_w[k], 6'(k), exp_last})
                $display("FAIL %s_word k=%0d got v=%b d=%h idx=%0d last=%b want v=1 d=%h idx=%0d last=%b",
                         name, k, w_valid, w_data, w_idx, w_last, exp_w[k], k, exp_last);
            else pass_cnt++;
            if (k == 5) begin
                chk_cnt++;
                if (blk_ready !== 1'b0) $display("FAIL %s_run_ready got=%b want=0", name, blk_ready);
                else pass_cnt++;
            end
            if (k == ROUNDS - 1 && w_ready) begin
                chk_cnt++;
                if (blk_ready !== B2B) $display("FAIL %s_last_ready got=%b want=%b", name, blk_ready, B2B);
                else pass_cnt++;
            end
            got[k] = w_data;
            if (w_ready) k++;
            @(negedge clk);
            budget++;
        end
        chk_cnt++;
        if (k != ROUNDS) $display("FAIL %s_timeout got=%0d words want=%0d", name, k, ROUNDS);
        else pass_cnt++;
        chk_cnt++;
        if (w_valid !== 1'b0) $display("FAIL %s_idle_after got=%b want=0", name, w_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; abort = 1'b0; blk_valid = 1'b0; w_ready = 1'b0; blk_data = '0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({blk_ready, w_valid, w_data, w_idx, w_last} !== {1'b1, 1'b0, 32'h0, 6'd0, 1'b0})
            $display("FAIL reset got rdy=%b v=%b d=%h idx=%0d last=%b want rdy=1 v=0 d=0 idx=0 last=0",
                     blk_ready, w_valid, w_data, w_idx, w_last);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_abc();
        set_abc();
        stream(1'b0, -1, "abc");
        chk_cnt++;
        if ({got[0], got[15], got[16], got[17]} !==
            {32'h6162_6380, 32'h0000_0018, 32'h6162_6380, 32'h000F_0000})
            $display("FAIL abc_known got %h %h %h %h want 61626380 00000018 61626380 000f0000",
                     got[0], got[15], got[16], got[17]);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        set_abc();
        stream(1'b1, -1, "stall_abc");
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
        stream(1'b1, -1, "stall_rand");
    endtask

    task automatic test_patterns();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0000_0000;
        stream(1'b0, -1, "zero");
        chk_cnt++;
        if (got[63] !== 32'h0000_0000) $display("FAIL zero_w63 got=%h want=00000000", got[63]);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) msg[i] = 32'hFFFF_FFFF;
        stream(1'b0, -1, "ones");
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) msg[i] = $urandom;
            stream(1'b0, -1, "rand");
        end
    endtask

    task automatic test_abort();
        set_abc();
        stream(1'b0, 20, "abort");
        set_abc();
        stream(1'b0, -1, "after_abort");
    endtask

    task automatic test_back_to_back();
        logic [31:0]  expab [128];
        logic [511:0] blk_a, blk_b;
        int k, cyc, acc, want_cyc;
        set_abc();
        compute_expected();
        for (int i = 0; i < 64; i++) expab[i] = exp_w[i];
        blk_a = pack_msg();
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
        compute_expected();
        for (int i = 0; i < 64; i++) expab[64+i] = exp_w[i];
        blk_b = pack_msg();
        want_cyc = B2B ? 129 : 130;
        @(negedge clk);
        w_ready = 1'b1; blk_data = blk_a; blk_valid = 1'b1;
        k = 0; cyc = 0; acc = 0;
        while (k < 128 && cyc < 400) begin
            if (acc == 1) blk_data = blk_b;
            if (acc == 2) blk_valid = 1'b0;
            if (w_valid) begin
                chk_cnt++;
                if ({w_data, w_idx} !== {expab[k], 6'(k % 64)})
                    $display("FAIL b2b_word k=%0d got d=%h idx=%0d want d=%h idx=%0d",
                             k, w_data, w_idx, expab[k], k % 64);
                else pass_cnt++;
                k++;
            end
            if (blk_valid && blk_ready) acc++;
            cyc++;
            @(negedge clk);
        end
        blk_valid = 1'b0;
        chk_cnt++;
        if (cyc != want_cyc || acc != 2)
            $display("FAIL b2b_cycles got cyc=%0d acc=%0d want cyc=%0d acc=2", cyc, acc, want_cyc);
        else pass_cnt++;
        chk_cnt++;
        if (w_valid !== 1'b0) $display("FAIL b2b_idle got=%b want=0", w_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_abc();
        test_backpressure();
        test_patterns();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
